// File: rtl/rep_string_sequencer_pkg.sv
// rtl/rep_string_sequencer_pkg.sv - state and rep-mode encodings for the string-instruction sequencer
`ifndef REP_SEQ_DEFS
`define REP_SEQ_DEFS
`define REP_NONE    2'b00
`define REP_E       2'b01
`define REP_NE      2'b10
`define ST_IDLE     3'd0
`define ST_CHECK    3'd1
`define ST_ISSUE1   3'd2
`define ST_ISSUE2   3'd3
`define ST_WAIT_ZF  3'd4
`define ST_ITER_END 3'd5
`define ST_DONE     3'd6
`endif

package rep_string_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = `ST_IDLE,
    S_CHECK    = `ST_CHECK,
    S_ISSUE1   = `ST_ISSUE1,
    S_ISSUE2   = `ST_ISSUE2,
    S_WAIT_ZF  = `ST_WAIT_ZF,
    S_ITER_END = `ST_ITER_END,
    S_DONE     = `ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REP_NONE = `REP_NONE,
    REP_E    = `REP_E,
    REP_NE   = `REP_NE
  } rep_mode_e;

  // The reserved encoding 2'b11 behaves as an unprefixed instruction.
  function automatic rep_mode_e norm_mode(input logic [1:0] m);
    case (m)
      `REP_E:  return REP_E;
      `REP_NE: return REP_NE;
      default: return REP_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rep_count_reg.sv
// rtl/rep_count_reg.sv - loadable ECX decrementer with one/zero flags
module rep_count_reg #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_m1,
  output logic             is_one,
  output logic             is_zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_m1  = cnt_q - CNT_W'(1);
  assign is_one  = (cnt_q == CNT_W'(1));
  assign is_zero = (cnt_q == '0);
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)     cnt_d = load_val;
    else if (dec) cnt_d = cnt_m1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rep_string_sequencer.sv
// rtl/rep_string_sequencer.sv - expands CMPS/REP string instructions into per-iteration uops for EX
// Optional REP_SEQ_PERF_CNT_EN builds a saturating completed-iteration counter on perf_iter.
module rep_string_sequencer
  import rep_string_sequencer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de_v,
  output logic             de_ready,
  input  logic             de_is_cmps,
  input  logic [1:0]       de_rep_mode,
  input  logic [CNT_W-1:0] de_count,
  input  logic             ex_ready,
  output logic             uop_v,
  output logic             uop_cmps_first,
  output logic             uop_cmps_second,
  output logic             uop_first_of_repne,
  output logic             uop_last,
  output logic [CNT_W-1:0] uop_count,
  input  logic             wb_v,
  input  logic             wb_zf,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [31:0]      perf_iter
);

  state_e           state_q, state_d;
  rep_mode_e        mode_q, mode_d;
  logic             is_cmps_q, is_cmps_d;
  logic             zf_q, zf_d;
  logic             first_q, first_d;
  logic             uop_v_q, uop_v_d;
  logic             cfirst_q, cfirst_d;
  logic             csecond_q, csecond_d;
  logic             repne_q, repne_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] ucount_q, ucount_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  logic             cnt_load, cnt_dec, cnt_is_one, cnt_is_zero;
  logic [CNT_W-1:0] cnt, cnt_m1;
  logic             xfer, rep_active, issue1, issue2, iter_tail;

  rep_count_reg #(.CNT_W(CNT_W)) u_count (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (de_count),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .cnt_m1   (cnt_m1),
    .is_one   (cnt_is_one),
    .is_zero  (cnt_is_zero)
  );

  assign xfer       = uop_v_q && ex_ready;
  assign rep_active = (mode_q != REP_NONE);

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    is_cmps_d = is_cmps_q;
    zf_d      = zf_q;
    first_d   = first_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (de_v && ready_q) begin
          cnt_load  = 1'b1;
          is_cmps_d = de_is_cmps;
          mode_d    = norm_mode(de_rep_mode);
          first_d   = 1'b1;
          state_d   = S_CHECK;
        end
        S_CHECK: state_d = (rep_active && cnt_is_zero) ? S_DONE : S_ISSUE1;
        S_ISSUE1: if (xfer) begin
          if (is_cmps_q) begin
            state_d = S_ISSUE2;
          end else begin
            cnt_dec = rep_active;
            state_d = S_ITER_END;
          end
        end
        S_ISSUE2: if (xfer) begin
          cnt_dec = rep_active;
          state_d = rep_active ? S_WAIT_ZF : S_ITER_END;
        end
        S_WAIT_ZF: if (wb_v) begin
          zf_d    = wb_zf;
          state_d = S_ITER_END;
        end
        S_ITER_END: begin
          first_d = 1'b0;
          if (!rep_active || cnt_is_zero ||
              (is_cmps_q && mode_q == REP_E && !zf_q) ||
              (is_cmps_q && mode_q == REP_NE && zf_q))
            state_d = S_DONE;
          else
            state_d = S_ISSUE1;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state; the count never moves while
  // entering or holding an issue state, so the current count image is exact.
  always_comb begin
    issue1    = (state_d == S_ISSUE1);
    issue2    = (state_d == S_ISSUE2);
    iter_tail = issue2 || (issue1 && !is_cmps_q);
    uop_v_d   = issue1 || issue2;
    cfirst_d  = issue1 && is_cmps_q;
    csecond_d = issue2;
    repne_d   = issue1 && (mode_q == REP_NE) && first_d;
    last_d    = iter_tail && (!rep_active || cnt_is_one);
    ucount_d  = !uop_v_d ? '0 : (iter_tail && rep_active) ? cnt_m1 : cnt;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    ready_d   = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= REP_NONE;
      is_cmps_q <= 1'b0;
      zf_q      <= 1'b0;
      first_q   <= 1'b0;
      uop_v_q   <= 1'b0;
      cfirst_q  <= 1'b0;
      csecond_q <= 1'b0;
      repne_q   <= 1'b0;
      last_q    <= 1'b0;
      ucount_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      is_cmps_q <= is_cmps_d;
      zf_q      <= zf_d;
      first_q   <= first_d;
      uop_v_q   <= uop_v_d;
      cfirst_q  <= cfirst_d;
      csecond_q <= csecond_d;
      repne_q   <= repne_d;
      last_q    <= last_d;
      ucount_q  <= ucount_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign de_ready           = ready_q;
  assign uop_v              = uop_v_q;
  assign uop_cmps_first     = cfirst_q;
  assign uop_cmps_second    = csecond_q;
  assign uop_first_of_repne = repne_q;
  assign uop_last           = last_q;
  assign uop_count          = ucount_q;
  assign busy               = busy_q;
  assign done               = done_q;

`ifdef REP_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (state_q == S_ITER_END && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_iter = perf_q;
`else
  assign perf_iter = '0;
`endif

endmodule

// File: tb/tb_rep_string_sequencer.sv
// tb/tb_rep_string_sequencer.sv - self-checking bench for rep_string_sequencer
module tb_rep_string_sequencer;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             de_v = 1'b0, de_is_cmps = 1'b0;
  logic [1:0]       de_rep_mode = 2'b00;
  logic [CNT_W-1:0] de_count = '0;
  logic             ex_ready = 1'b0, wb_v = 1'b0, wb_zf = 1'b0, flush = 1'b0;
  logic             de_ready, uop_v, uop_cmps_first, uop_cmps_second, uop_first_of_repne, uop_last;
  logic [CNT_W-1:0] uop_count;
  logic             busy, done;
  logic [31:0]      perf_iter;

  rep_string_sequencer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .de_v(de_v), .de_ready(de_ready), .de_is_cmps(de_is_cmps),
    .de_rep_mode(de_rep_mode), .de_count(de_count), .ex_ready(ex_ready), .uop_v(uop_v),
    .uop_cmps_first(uop_cmps_first), .uop_cmps_second(uop_cmps_second),
    .uop_first_of_repne(uop_first_of_repne), .uop_last(uop_last), .uop_count(uop_count),
    .wb_v(wb_v), .wb_zf(wb_zf), .flush(flush), .busy(busy), .done(done), .perf_iter(perf_iter)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             first;
    logic             second;
    logic             repne;
    logic             last;
    logic [CNT_W-1:0] cnt;
  } uop_t;

  typedef struct {
    logic             cmps;
    logic [1:0]       mode;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       zf;
    int               exp_n;
    logic [CNT_W-1:0] exp_last;
  } vec_t;

  int               vectors = 0;
  int               errors = 0;
  uop_t             exp_q[$];
  int               last_n;
  logic [CNT_W-1:0] last_cnt;
  vec_t             tbl[9];
  uop_t             snap;
  int               seen;
  logic             r_c;
  logic [1:0]       r_m;
  logic [CNT_W-1:0] r_n;
  logic [7:0]       r_z;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic uop_t cur_uop();
    uop_t u;
    u.first = uop_cmps_first; u.second = uop_cmps_second; u.repne = uop_first_of_repne;
    u.last = uop_last; u.cnt = uop_count;
    return u;
  endfunction

  function automatic uop_t mk(input logic f, input logic s, input logic r, input logic l, input logic [CNT_W-1:0] c);
    uop_t u;
    u.first = f; u.second = s; u.repne = r; u.last = l; u.cnt = c;
    return u;
  endfunction

  // Reference: list every uop the instruction must produce, iteration by iteration.
  task automatic build_model(input logic cmps, input logic [1:0] mode_in, input logic [CNT_W-1:0] count,
                             input logic [7:0] zf_bits);
    logic [1:0]       m;
    logic [CNT_W-1:0] c, nc;
    logic             rep, lst, zf, rn;
    m = (mode_in == 2'b11) ? 2'b00 : mode_in;
    rep = (m != 2'b00);
    exp_q.delete();
    c = count;
    if (rep && c == 0) return;
    for (int it = 0; it < 64; it++) begin
      nc  = rep ? c - 1 : c;
      lst = !rep || (c == 1);
      rn  = (m == 2'b10) && (it == 0);
      zf  = zf_bits[it % 8];
      if (cmps) begin
        exp_q.push_back(mk(1'b1, 1'b0, rn, 1'b0, c));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, lst, nc));
      end else begin
        exp_q.push_back(mk(1'b0, 1'b0, rn, lst, nc));
      end
      c = nc;
      if (!rep || c == 0 || (cmps && m == 2'b01 && !zf) || (cmps && m == 2'b10 && zf)) break;
    end
  endtask

  task automatic run_instr(input logic cmps, input logic [1:0] mode, input logic [CNT_W-1:0] cnt,
                           input logic [7:0] zf_bits, input int stall_pct);
    int   got = 0, wbk = 0, wb_dly = 0, n_exp;
    bit   wb_pend = 0, done_seen = 0, hold = 0;
    logic rep;
    uop_t prev;
    build_model(cmps, mode, cnt, zf_bits);
    n_exp = exp_q.size();
    rep = (mode == 2'b01) || (mode == 2'b10);
    @(negedge clk);
    chk("accept_ready", de_ready, 1);
    de_v = 1'b1; de_is_cmps = cmps; de_rep_mode = mode; de_count = cnt; ex_ready = 1'b0;
    @(negedge clk);
    de_v = 1'b0;
    for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
      wb_v = 1'b0;
      if (hold) chk("hold_stable", {uop_v, cur_uop()}, {1'b1, prev});
      hold = 0;
      if (done) begin
        done_seen = 1;
        chk("uop_total", got, n_exp);
      end else begin
        if (wb_pend) begin
          if (wb_dly == 0) begin
            wb_v = 1'b1; wb_zf = zf_bits[wbk % 8]; wbk++; wb_pend = 0;
          end else wb_dly--;
        end
        if (uop_v) begin
          ex_ready = ($urandom_range(99) >= stall_pct);
          if (ex_ready) begin
            if (got < n_exp) chk("uop_fields", cur_uop(), exp_q[got]);
            else chk("uop_overrun", got + 1, n_exp);
            last_cnt = uop_count;
            if (uop_cmps_second && rep) begin wb_pend = 1; wb_dly = $urandom_range(3); end
            got++;
          end else begin
            hold = 1; prev = cur_uop();
          end
        end else ex_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
    end
    last_n = got;
    chk("done_seen", done_seen, 1);
    wb_v = 1'b0; ex_ready = 1'b0;
    chk("idle_after_done", {de_ready, busy, done, uop_v}, 4'b1000);
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'b01, 32'd3,          8'hFF, 6, 32'd0};
    tbl[1] = '{1'b1, 2'b10, 32'd5,          8'h02, 4, 32'd3};
    tbl[2] = '{1'b1, 2'b00, 32'd9,          8'h00, 2, 32'd9};
    tbl[3] = '{1'b0, 2'b01, 32'd4,          8'h00, 4, 32'd0};
    tbl[4] = '{1'b0, 2'b10, 32'd2,          8'h00, 2, 32'd0};
    tbl[5] = '{1'b0, 2'b11, 32'd0,          8'h00, 1, 32'd0};
    tbl[6] = '{1'b1, 2'b01, 32'd1,          8'hFF, 2, 32'd0};
    tbl[7] = '{1'b1, 2'b01, 32'd0,          8'hFF, 0, 32'd0};
    tbl[8] = '{1'b1, 2'b01, 32'hFFFF_FFFF,  8'h03, 6, 32'hFFFF_FFFC};

    @(negedge clk); @(negedge clk);
    chk("reset_state", {de_ready, uop_v, uop_cmps_first, uop_cmps_second, uop_first_of_repne,
                        uop_last, busy, done}, 8'b1000_0000);
    chk("reset_count", {uop_count, perf_iter}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].cmps, tbl[i].mode, tbl[i].cnt, tbl[i].zf, 30);
      chk("tbl_uop_n", last_n, tbl[i].exp_n);
      if (tbl[i].exp_n > 0) chk("tbl_last_cnt", last_cnt, tbl[i].exp_last);
    end

    // REP with count 0: straight to DONE, no uop.
    @(negedge clk);
    de_v = 1'b1; de_is_cmps = 1'b0; de_rep_mode = 2'b01; de_count = '0; ex_ready = 1'b1;
    @(negedge clk); de_v = 1'b0;
    chk("cnt0_check", {uop_v, done, busy}, 3'b001);
    @(negedge clk);
    chk("cnt0_done", {uop_v, done}, 2'b01);
    @(negedge clk);
    chk("cnt0_idle", {done, de_ready}, 2'b01);

    // Unprefixed single uop held by EX back-pressure.
    de_v = 1'b1; de_is_cmps = 1'b0; de_rep_mode = 2'b00; de_count = 32'd7; ex_ready = 1'b0;
    @(negedge clk); de_v = 1'b0;
    chk("lat_check", uop_v, 0);
    @(negedge clk);
    chk("lat_first_uop", {uop_v, cur_uop()}, {1'b1, mk(1'b0, 1'b0, 1'b0, 1'b1, 32'd7)});
    snap = cur_uop();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold", {uop_v, cur_uop()}, {1'b1, snap});
    end
    ex_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (uop_v) seen++;
      if (k == 1) chk("stall_done", done, 1);
    end
    chk("stall_one_xfer", seen, 0);

    // Flush while waiting for ZF.
    ex_ready = 1'b1;
    de_v = 1'b1; de_is_cmps = 1'b1; de_rep_mode = 2'b01; de_count = 32'd4;
    @(negedge clk); de_v = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("flush_wait_zf", {busy, uop_v}, 2'b10);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("flush_idle", {de_ready, busy, done}, 3'b100);
    wb_v = 1'b1; wb_zf = 1'b1;
    @(negedge clk); wb_v = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      if (done || uop_v || busy) seen++;
      @(negedge clk);
    end
    chk("flush_quiet", seen, 0);
    run_instr(1'b1, 2'b01, 32'd2, 8'hFF, 0);

    // Asynchronous reset while the second CMPS uop is presented.
    ex_ready = 1'b1;
    de_v = 1'b1; de_is_cmps = 1'b1; de_rep_mode = 2'b01; de_count = 32'd3;
    @(negedge clk); de_v = 1'b0;
    @(negedge clk);
    @(negedge clk); ex_ready = 1'b0;
    chk("rst_in_issue2", uop_cmps_second, 1);
    #2 rst = 1'b1;
    #1 chk("rst_async", {uop_v, uop_cmps_second, uop_count, busy, de_ready}, {2'b00, 32'd0, 2'b01});
    @(negedge clk); rst = 1'b0;
    run_instr(1'b1, 2'b10, 32'd3, 8'h00, 20);
    chk("rst_recover_n", last_n, 6);

    for (int i = 0; i < 40; i++) begin
      r_c = 1'($urandom_range(1));
      r_m = 2'($urandom_range(3));
      r_n = $urandom_range(6);
      r_z = 8'($urandom);
      if (r_c && (r_m == 2'b01 || r_m == 2'b10) && $urandom_range(3) == 0) begin
        r_n = 32'hFFFF_FFF0 + $urandom_range(15);
        r_z[7] = (r_m == 2'b10);
      end
      run_instr(r_c, r_m, r_n, r_z, 40);
    end

`ifndef REP_SEQ_PERF_CNT_EN
    chk("perf_tied_off", perf_iter, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
